// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes a bouncy asynchronous line, accepts a new level only
// after it has been stable for STABLE_CYCLES, and emits press/release/auto-repeat strobes.
module button_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 32,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_repeat,
  output logic [1:0] state_dbg
);

  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned STAB_W   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_e;

  state_e                   state_q,       state_d;
  logic [SYNC_STAGES-1:0]   sync_q,        sync_d;
  logic [STAB_W-1:0]        stab_cnt_q,    stab_cnt_d;
  logic [HOLD_W-1:0]        hold_cnt_q,    hold_cnt_d;
  logic                     rep_phase_q,   rep_phase_d;
  logic                     btn_level_q,   btn_level_d;
  logic                     btn_press_q,   btn_press_d;
  logic                     btn_release_q, btn_release_d;
  logic                     btn_repeat_q,  btn_repeat_d;
  logic                     btn_sync;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], btn_raw};
    state_d       = state_q;
    stab_cnt_d    = stab_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    rep_phase_d   = rep_phase_q;
    btn_level_d   = btn_level_q;
    btn_press_d   = 1'b0;
    btn_release_d = 1'b0;
    btn_repeat_d  = 1'b0;

    unique case (state_q)
      RELEASED: begin
        btn_level_d = 1'b0;
        if (btn_sync) begin
          stab_cnt_d = STAB_ONE;
          state_d    = PRESS_PEND;
        end
      end

      PRESS_PEND: begin
        if (!btn_sync) begin
          stab_cnt_d = '0;
          state_d    = RELEASED;
        end else if (stab_cnt_q == STAB_LAST) begin
          stab_cnt_d  = '0;
          hold_cnt_d  = '0;
          rep_phase_d = 1'b0;
          btn_level_d = 1'b1;
          btn_press_d = 1'b1;
          state_d     = PRESSED;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end

      // rep_phase selects the initial hold interval versus the shorter repeat interval
      PRESSED: begin
        if (!btn_sync) begin
          stab_cnt_d = STAB_ONE;
          state_d    = RELEASE_PEND;
        end else if (hold_cnt_q == (rep_phase_q ? REP_LAST : HOLD_LAST)) begin
          hold_cnt_d   = '0;
          rep_phase_d  = 1'b1;
          btn_repeat_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end

      RELEASE_PEND: begin
        if (btn_sync) begin
          stab_cnt_d = '0;
          state_d    = PRESSED;
        end else if (stab_cnt_q == STAB_LAST) begin
          stab_cnt_d    = '0;
          btn_level_d   = 1'b0;
          btn_release_d = 1'b1;
          state_d       = RELEASED;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end

      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q       <= RELEASED;
      sync_q        <= '0;
      stab_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      rep_phase_q   <= 1'b0;
      btn_level_q   <= 1'b0;
      btn_press_q   <= 1'b0;
      btn_release_q <= 1'b0;
      btn_repeat_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      stab_cnt_q    <= stab_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      rep_phase_q   <= rep_phase_d;
      btn_level_q   <= btn_level_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      btn_repeat_q  <= btn_repeat_d;
    end
  end

  assign btn_level   = btn_level_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;
  assign btn_repeat  = btn_repeat_q;
  assign state_dbg   = state_q;

  a_one_strobe: assert property (@(posedge clk_fast)
    $onehot0({btn_press_q, btn_release_q, btn_repeat_q}));

endmodule
